multicycle_ctrl: RTL and testbench

//  Control FSM sequencing the multicycle RV32I datapath through IF/ID/EX/MEM/WB, one instruction per pass.

---
 rtl/multicycle_ctrl_pkg.sv | 56 +++++
 rtl/multicycle_ctrl_if.sv | 42 ++++
 rtl/multicycle_ctrl_alu_decoder.sv | 43 ++++
 rtl/multicycle_ctrl.sv | 111 +++++++++++
 tb/tb_multicycle_ctrl.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Purpose: shared encodings for the multicycle RV32I controller (states, opcodes, branch funct3, ALU codes).
// Latency: n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
// Ports: none. Optional feature macro used elsewhere: MULTICYCLE_CTRL_MEM_STALL_EN.
package multicycle_ctrl_pkg;

    // Five-state instruction pass; codes 3'b101..3'b111 are never entered.
    typedef enum logic [2:0] {
        ST_IF  = 3'b000,
        ST_ID  = 3'b001,
        ST_EX  = 3'b010,
        ST_MEM = 3'b011,
        ST_WB  = 3'b100
    } state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SLL = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_SRL = 4'b0101,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_SRA = 4'b1000
    } aluctr_e;

    // Maps funct3 to an ALU op. alt_sub selects SUB for f3=000, alt_sra selects
    // SRA for f3=101; SLTU has no dedicated code and shares SLT.
    function automatic aluctr_e f3_to_aluctr(input logic [2:0] f3,
                                             input logic       alt_sub,
                                             input logic       alt_sra);
        aluctr_e op;
        case (f3)
            3'b000:  op = alt_sub ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLT;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt_sra ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Purpose: controller <-> datapath bundle: instruction/flags in, per-state strobes and ALU controls out.
// Latency: n/a (wires only).
// Backpressure: dReady (only with MULTICYCLE_CTRL_MEM_STALL_EN) lets data memory hold the MEM state.
// Modports: master = controller (drives strobes), slave = datapath/fetch side (drives instr, Zero, dReady).
interface multicycle_ctrl_if #(
    parameter int ALUCTR_W = 4
);
    logic [31:0]         instr;
    logic                Zero;
`ifdef MULTICYCLE_CTRL_MEM_STALL_EN
    logic                dReady;
`endif
    logic                loadPC;
    logic                PCSrc;
    logic                MemRead;
    logic                MemWrite;
    logic                RegWrite;
    logic                MemToReg;
    logic                ALUSrc;
    logic [ALUCTR_W-1:0] ALUCtr;
    logic [2:0]          fsm_state;

`ifdef MULTICYCLE_CTRL_MEM_STALL_EN
    modport master (
        input  instr, Zero, dReady,
        output loadPC, PCSrc, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc, ALUCtr, fsm_state
    );
    modport slave (
        output instr, Zero, dReady,
        input  loadPC, PCSrc, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc, ALUCtr, fsm_state
    );
`else
    modport master (
        input  instr, Zero,
        output loadPC, PCSrc, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc, ALUCtr, fsm_state
    );
    modport slave (
        output instr, Zero,
        input  loadPC, PCSrc, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc, ALUCtr, fsm_state
    );
`endif
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Purpose: combinational instr-field decode to ALU operation and B-operand select.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: opcode/funct3/funct7_b5 in; alu_ctr (4b code), alu_src (1 = immediate) out.
module alu_decoder
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_b5,
    output aluctr_e    alu_ctr,
    output logic       alu_src
);

    always_comb begin
        alu_ctr = ALU_ADD;
        alu_src = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_STORE: begin
                alu_ctr = ALU_ADD;
                alu_src = 1'b1;
            end
            OPC_BRANCH: begin
                alu_ctr = ALU_SUB;
                alu_src = 1'b0;
            end
            OPC_OP: begin
                alu_ctr = f3_to_aluctr(funct3, funct7_b5, funct7_b5);
                alu_src = 1'b0;
            end
            OPC_OPIMM: begin
                // Bit 30 is part of the immediate except for SRAI, so it never selects SUB here.
                alu_ctr = f3_to_aluctr(funct3, 1'b0, funct7_b5);
                alu_src = 1'b1;
            end
            default: begin
                alu_ctr = ALU_ADD;
                alu_src = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Purpose: IF/ID/EX/MEM/WB sequencer for the multicycle RV32I datapath; registered per-state strobes.
// Latency: 5 cycles per instruction (loadPC in WB); MEM may stretch with MULTICYCLE_CTRL_MEM_STALL_EN.
// Backpressure: with MULTICYCLE_CTRL_MEM_STALL_EN, LOAD/STORE hold MEM (strobe high) until dReady=1.
// Ports: clk, rst (sync, active-high), bus (multicycle_ctrl_if.master: instr, Zero, [dReady] in;
//        loadPC, PCSrc, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc, ALUCtr, fsm_state out).
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int ALUCTR_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    multicycle_ctrl_if.master  bus
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_reg_write;
    logic       mem_ready;

    aluctr_e    alu_ctr;
    logic       alu_src;

    state_e     state_q, state_d;
    logic       taken_q, taken_d;
    logic       load_pc_q, load_pc_d;
    logic       pc_src_q, pc_src_d;
    logic       mem_read_q, mem_read_d;
    logic       mem_write_q, mem_write_d;
    logic       reg_write_q, reg_write_d;

    assign opcode       = bus.instr[6:0];
    assign funct3       = bus.instr[14:12];
    assign is_load      = (opcode == OPC_LOAD);
    assign is_store     = (opcode == OPC_STORE);
    assign is_branch    = (opcode == OPC_BRANCH) && ((funct3 == F3_BEQ) || (funct3 == F3_BNE));
    assign is_reg_write = is_load || (opcode == OPC_OP) || (opcode == OPC_OPIMM);

`ifdef MULTICYCLE_CTRL_MEM_STALL_EN
    assign mem_ready = bus.dReady;
`else
    assign mem_ready = 1'b1;
`endif

    alu_decoder u_alu_decoder (
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7_b5 (bus.instr[30]),
        .alu_ctr   (alu_ctr),
        .alu_src   (alu_src)
    );

    always_comb begin
        state_d = ST_IF;
        case (state_q)
            ST_IF:   state_d = ST_ID;
            ST_ID:   state_d = ST_EX;
            ST_EX:   state_d = ST_MEM;
            ST_MEM:  state_d = ((is_load || is_store) && !mem_ready) ? ST_MEM : ST_WB;
            ST_WB:   state_d = ST_IF;
            default: state_d = ST_IF;
        endcase

        // BNE is BEQ with the Zero sense flipped; funct3[0] distinguishes them.
        taken_d = taken_q;
        if (state_q == ST_EX) begin
            taken_d = is_branch && (bus.Zero ^ funct3[0]);
        end

        // Strobes are registered, so they are decoded from the state being entered.
        mem_read_d  = (state_d == ST_MEM) && is_load;
        mem_write_d = (state_d == ST_MEM) && is_store;
        load_pc_d   = (state_d == ST_WB);
        pc_src_d    = (state_d == ST_WB) && taken_d;
        reg_write_d = (state_d == ST_WB) && is_reg_write;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IF;
            taken_q     <= 1'b0;
            load_pc_q   <= 1'b0;
            pc_src_q    <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            reg_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            taken_q     <= taken_d;
            load_pc_q   <= load_pc_d;
            pc_src_q    <= pc_src_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            reg_write_q <= reg_write_d;
        end
    end

    assign bus.loadPC    = load_pc_q;
    assign bus.PCSrc     = pc_src_q;
    assign bus.MemRead   = mem_read_q;
    assign bus.MemWrite  = mem_write_q;
    assign bus.RegWrite  = reg_write_q;
    assign bus.MemToReg  = is_load;
    assign bus.ALUSrc    = alu_src;
    assign bus.ALUCtr    = ALUCTR_W'(alu_ctr);
    assign bus.fsm_state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Purpose: directed scoreboard bench for multicycle_ctrl; expected output records queued per cycle.
// Latency: checks every cycle of each 5-cycle pass (longer MEM with MULTICYCLE_CTRL_MEM_STALL_EN).
// Backpressure: dReady driven only when MULTICYCLE_CTRL_MEM_STALL_EN is defined.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       lpc;
        logic       pcs;
        logic       mr;
        logic       mw;
        logic       rw;
        logic       m2r;
        logic       asrc;
        logic [3:0] ctr;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks   = 0;
    int    failures = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.ALUCTR_W(4)) bus ();

    multicycle_ctrl #(.ALUCTR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string nm, input logic [2:0] st, input logic lpc, input logic pcs,
                        input logic mr, input logic mw, input logic rw, input logic m2r,
                        input logic asrc, input logic [3:0] ctr);
        exp_t e;
        e = '{st: st, lpc: lpc, pcs: pcs, mr: mr, mw: mw, rw: rw, m2r: m2r, asrc: asrc, ctr: ctr};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Called at posedge+1 of an IF cycle; leaves the bench at posedge+1 of the next IF.
    task automatic run_instr(input string nm, input logic [31:0] ins, input logic z,
                             input logic [3:0] ctr, input logic asrc, input logic m2r,
                             input logic mr, input logic mw, input logic rw, input logic pcs);
        bus.instr = ins;
        bus.Zero  = z;
        push({nm, "/IF"},  3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m2r, asrc, ctr); tick();
        push({nm, "/ID"},  3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m2r, asrc, ctr); tick();
        push({nm, "/EX"},  3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, m2r, asrc, ctr); tick();
        push({nm, "/MEM"}, 3'd3, 1'b0, 1'b0, mr,   mw,   1'b0, m2r, asrc, ctr); tick();
        push({nm, "/WB"},  3'd4, 1'b1, pcs,  1'b0, 1'b0, rw,   m2r, asrc, ctr); tick();
    endtask

    // Monitor: compares one queued record against the DUT on every falling edge.
    initial begin
        exp_t  e;
        exp_t  a;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = '{st: bus.fsm_state, lpc: bus.loadPC, pcs: bus.PCSrc, mr: bus.MemRead,
                       mw: bus.MemWrite, rw: bus.RegWrite, m2r: bus.MemToReg, asrc: bus.ALUSrc,
                       ctr: bus.ALUCtr};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL %s: got st=%0d lpc=%b pcs=%b mr=%b mw=%b rw=%b m2r=%b asrc=%b ctr=%b, want st=%0d lpc=%b pcs=%b mr=%b mw=%b rw=%b m2r=%b asrc=%b ctr=%b",
                             nm, a.st, a.lpc, a.pcs, a.mr, a.mw, a.rw, a.m2r, a.asrc, a.ctr,
                             e.st, e.lpc, e.pcs, e.mr, e.mw, e.rw, e.m2r, e.asrc, e.ctr);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.instr = 32'h0000_0000;
        bus.Zero  = 1'b0;
`ifdef MULTICYCLE_CTRL_MEM_STALL_EN
        bus.dReady = 1'b1;
`endif
        rst = 1'b1;
        tick();
        tick();
        // Reset state with instr=0 (unknown opcode): IF, no strobes, ALUCtr=ADD, ALUSrc=0.
        push("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010);
        tick();
        rst = 1'b0;

        //         name        instr         Z     ctr      asrc  m2r   mr    mw    rw    pcs
        run_instr("addi_x0",  32'h0000_0013, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_instr("lw",       32'h0000_A283, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        run_instr("sw",       32'h0051_2023, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_instr("sub",      32'h4020_8033, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_instr("beq_z1",   32'h0020_8463, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_instr("beq_z0",   32'h0020_8463, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr("bne_z1",   32'h0020_9463, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr("bne_z0",   32'h0020_9463, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_instr("srai",     32'h4050_D093, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_instr("addi_b30", 32'h4000_0093, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_instr("xor",      32'h0031_40B3, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_instr("srl",      32'h0031_50B3, 1'b0, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset in MEM of a store: the following cycle must be IF with no MemWrite and no loadPC.
        bus.instr = 32'h0051_2023;
        push("sw_abort/IF",  3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010); tick();
        push("sw_abort/ID",  3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010); tick();
        push("sw_abort/EX",  3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010); tick();
        push("sw_abort/MEM", 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0010);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        // Its IF record doubles as the post-abort check.
        run_instr("unknown",  32'h0000_007F, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr("lw2",      32'h0000_A283, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

`ifdef MULTICYCLE_CTRL_MEM_STALL_EN
        // LW with dReady low for three MEM cycles: MEM lasts four cycles, MemRead high throughout.
        bus.instr  = 32'h0000_A283;
        bus.Zero   = 1'b0;
        bus.dReady = 1'b0;
        push("lw_stall/IF",   3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010); tick();
        push("lw_stall/ID",   3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010); tick();
        push("lw_stall/EX",   3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010); tick();
        for (int i = 0; i < 3; i++) begin
            push("lw_stall/MEMw", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010); tick();
        end
        bus.dReady = 1'b1;
        push("lw_stall/MEMr", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0010); tick();
        push("lw_stall/WB",   3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0010); tick();
        // A non-memory op must ignore a low dReady.
        bus.dReady = 1'b0;
        run_instr("addi_nordy", 32'h0000_0013, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        bus.dReady = 1'b1;
`endif

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d records left unchecked, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
